// File: rtl/floo_eos_quiesce_monitor.sv
// End-of-simulation monitor: latches cluster EOS flags, tracks outstanding AXI
// write/read bursts per port, requires a quiet drain window before declaring done.
// Latency: all outputs registered; done one cycle after the last drain cycle. No backpressure (observe-only).
module floo_eos_quiesce_monitor #(
    parameter int unsigned NumClusters   = 4,
    parameter int unsigned NumPorts      = 8,
    parameter int unsigned OutstWidth    = 8,
    parameter int unsigned DrainCycles   = 100,
    parameter int unsigned TimeoutCycles = 1000000,
    parameter int unsigned CycleCntWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumClusters-1:0]   cluster_eos_i,
    input  logic [NumPorts-1:0]      aw_fire_i,
    input  logic [NumPorts-1:0]      b_fire_i,
    input  logic [NumPorts-1:0]      ar_fire_i,
    input  logic [NumPorts-1:0]      r_last_fire_i,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     error_o,
    output logic [1:0]               state_o,
    output logic [CycleCntWidth-1:0] cycle_cnt_o
);

    localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam logic [DrainW-1:0]        DrainLast   = DrainW'(DrainCycles - 1);
    localparam logic [CycleCntWidth-1:0] TimeoutLast = CycleCntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StDone    = 2'd2,
        StTimeout = 2'd3
    } state_e;

    state_e                              state_q;
    logic [DrainW-1:0]                   drain_cnt_q;
    logic [CycleCntWidth-1:0]            cycle_cnt_q;
    logic [NumClusters-1:0]              eos_q;
    logic                                done_q;
    logic                                timeout_q;
    logic                                error_q;
    logic [NumPorts-1:0][OutstWidth-1:0] wr_cnt_q;
    logic [NumPorts-1:0][OutstWidth-1:0] rd_cnt_q;
    logic [NumPorts-1:0][OutstWidth-1:0] wr_cnt_d;
    logic [NumPorts-1:0][OutstWidth-1:0] rd_cnt_d;
    logic [NumPorts-1:0]                 wr_err;
    logic [NumPorts-1:0]                 rd_err;
    logic                                all_eos;
    logic                                any_fire;
    logic                                cnt_zero;
    logic                                quiet;
    logic                                timeout_hit;

    // Returns {error, next_count}; an illegal step holds the count and flags it.
    function automatic logic [OutstWidth:0] cnt_upd(input logic [OutstWidth-1:0] cnt,
                                                    input logic inc,
                                                    input logic dec);
        logic [OutstWidth-1:0] nxt;
        logic                  err;
        nxt = cnt;
        err = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (&cnt) err = 1'b1;
                else      nxt = cnt + 1'b1;
            end
            2'b01: begin
                if (cnt == '0) err = 1'b1;
                else           nxt = cnt - 1'b1;
            end
            default: nxt = cnt;
        endcase
        return {err, nxt};
    endfunction

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_err   = '0;
        rd_err   = '0;
        cnt_zero = 1'b1;
        for (int p = 0; p < NumPorts; p++) begin
            {wr_err[p], wr_cnt_d[p]} = cnt_upd(wr_cnt_q[p], aw_fire_i[p], b_fire_i[p]);
            {rd_err[p], rd_cnt_d[p]} = cnt_upd(rd_cnt_q[p], ar_fire_i[p], r_last_fire_i[p]);
            if (wr_cnt_q[p] != '0 || rd_cnt_q[p] != '0) cnt_zero = 1'b0;
        end
    end

    assign all_eos     = &eos_q;
    assign any_fire    = |{aw_fire_i, b_fire_i, ar_fire_i, r_last_fire_i};
    assign quiet       = cnt_zero && !any_fire;
    assign timeout_hit = (cycle_cnt_q == TimeoutLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            cycle_cnt_q <= '0;
            eos_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            eos_q    <= eos_q | cluster_eos_i;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (!(&cycle_cnt_q)) cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if ((|wr_err) || (|rd_err) || (state_q == StDone && any_fire)) error_q <= 1'b1;

            case (state_q)
                StRun: begin
                    if (timeout_hit) begin
                        state_q   <= StTimeout;
                        timeout_q <= 1'b1;
                    end else if (all_eos) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= '0;
                    end
                end
                StDrain: begin
                    // Timeout takes priority over a coincident completion.
                    if (timeout_hit) begin
                        state_q   <= StTimeout;
                        timeout_q <= 1'b1;
                    end else if (quiet) begin
                        if (drain_cnt_q == DrainLast) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= '0;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign error_o     = error_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_floo_eos_quiesce_monitor.sv
// Table-driven bench: per-scenario input events and expected output checks keyed by cycle
// number (cycle k = the cycle in which cycle_cnt_o == k), plus a hand sequence for async reset.
module tb_floo_eos_quiesce_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cluster_eos = '0;
    logic [7:0]  aw_fire = '0;
    logic [7:0]  b_fire = '0;
    logic [7:0]  ar_fire = '0;
    logic [7:0]  r_last_fire = '0;
    logic        done;
    logic        timeout;
    logic        error;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    floo_eos_quiesce_monitor #(
        .NumClusters  (4),
        .NumPorts     (8),
        .OutstWidth   (2),
        .DrainCycles  (4),
        .TimeoutCycles(50),
        .CycleCntWidth(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cluster_eos_i(cluster_eos),
        .aw_fire_i    (aw_fire),
        .b_fire_i     (b_fire),
        .ar_fire_i    (ar_fire),
        .r_last_fire_i(r_last_fire),
        .done_o       (done),
        .timeout_o    (timeout),
        .error_o      (error),
        .state_o      (state),
        .cycle_cnt_o  (cycle_cnt)
    );

    typedef struct {
        int         scn;
        int         cyc;
        bit         chk;
        logic [3:0] eos;
        logic [7:0] aw, b, ar, rl;
        logic [1:0] st;
        logic       dn, to, er;
    } vec_t;

    vec_t vecs[$];

    task automatic add_in(input int s, input int c, input logic [3:0] e,
                          input logic [7:0] aw, input logic [7:0] b,
                          input logic [7:0] ar, input logic [7:0] rl);
        vec_t v;
        v = '{scn: s, cyc: c, chk: 1'b0, eos: e, aw: aw, b: b, ar: ar, rl: rl,
              st: 2'd0, dn: 1'b0, to: 1'b0, er: 1'b0};
        vecs.push_back(v);
    endtask

    task automatic add_chk(input int s, input int c, input logic [1:0] st,
                           input logic dn, input logic to, input logic er);
        vec_t v;
        v = '{scn: s, cyc: c, chk: 1'b1, eos: 4'h0, aw: 8'h0, b: 8'h0, ar: 8'h0, rl: 8'h0,
              st: st, dn: dn, to: to, er: er};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        cluster_eos = '0;
        aw_fire     = '0;
        b_fire      = '0;
        ar_fire     = '0;
        r_last_fire = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        // 1: all EOS pulse at cycle 10, no traffic
        add_in (1, 10, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_chk(1, 0, 2'd0, 0, 0, 0);
        add_chk(1, 11, 2'd0, 0, 0, 0);
        add_chk(1, 12, 2'd1, 0, 0, 0);
        add_chk(1, 15, 2'd1, 0, 0, 0);
        add_chk(1, 16, 2'd2, 1, 0, 0);
        add_chk(1, 20, 2'd2, 1, 0, 0);
        // 2: outstanding write on port 3 delays the drain window
        add_in (2, 5, 4'h0, 8'h08, 8'h00, 8'h00, 8'h00);
        add_in (2, 6, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_in (2, 20, 4'h0, 8'h00, 8'h08, 8'h00, 8'h00);
        add_chk(2, 8, 2'd1, 0, 0, 0);
        add_chk(2, 24, 2'd1, 0, 0, 0);
        add_chk(2, 25, 2'd2, 1, 0, 0);
        // 3: same-cycle AR + R-last interrupts the drain after 3 quiet cycles
        add_in (3, 2, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_in (3, 7, 4'h0, 8'h00, 8'h00, 8'h01, 8'h01);
        add_chk(3, 7, 2'd1, 0, 0, 0);
        add_chk(3, 11, 2'd1, 0, 0, 0);
        add_chk(3, 12, 2'd2, 1, 0, 0);
        // 4a: B underflow on port 7 flags error, FSM proceeds normally
        add_in (4, 3, 4'h0, 8'h00, 8'h80, 8'h00, 8'h00);
        add_in (4, 5, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_chk(4, 3, 2'd0, 0, 0, 0);
        add_chk(4, 4, 2'd0, 0, 0, 1);
        add_chk(4, 7, 2'd1, 0, 0, 1);
        add_chk(4, 11, 2'd2, 1, 0, 1);
        // 4b: 4 AWs on 2-bit counter saturate at 3; two Bs leave one outstanding
        for (int c = 2; c <= 5; c++) add_in(5, c, 4'h0, 8'h02, 8'h00, 8'h00, 8'h00);
        add_in (5, 6, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_in (5, 8, 4'h0, 8'h00, 8'h02, 8'h00, 8'h00);
        add_in (5, 9, 4'h0, 8'h00, 8'h02, 8'h00, 8'h00);
        add_in (5, 20, 4'h0, 8'h00, 8'h02, 8'h00, 8'h00);
        add_chk(5, 5, 2'd0, 0, 0, 0);
        add_chk(5, 6, 2'd0, 0, 0, 1);
        add_chk(5, 8, 2'd1, 0, 0, 1);
        add_chk(5, 20, 2'd1, 0, 0, 1);
        add_chk(5, 25, 2'd2, 1, 0, 1);
        // 5: cluster 2 never finishes -> watchdog; late EOS ignored
        add_in (6, 2, 4'hB, 8'h00, 8'h00, 8'h00, 8'h00);
        add_in (6, 52, 4'h4, 8'h00, 8'h00, 8'h00, 8'h00);
        add_chk(6, 49, 2'd0, 0, 0, 0);
        add_chk(6, 50, 2'd3, 0, 1, 0);
        add_chk(6, 55, 2'd3, 0, 1, 0);
        // traffic after completion flags error, done stays
        add_in (7, 0, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
        add_in (7, 8, 4'h0, 8'h04, 8'h00, 8'h00, 8'h00);
        add_chk(7, 6, 2'd2, 1, 0, 0);
        add_chk(7, 8, 2'd2, 1, 0, 0);
        add_chk(7, 9, 2'd2, 1, 0, 1);
        // done condition coincides with watchdog cycle -> timeout wins
        add_in (8, 2, 4'hF, 8'h01, 8'h00, 8'h00, 8'h00);
        add_in (8, 45, 4'h0, 8'h00, 8'h01, 8'h00, 8'h00);
        add_chk(8, 48, 2'd1, 0, 0, 0);
        add_chk(8, 50, 2'd3, 0, 1, 0);

        for (int s = 1; s <= 8; s++) begin
            int maxc;
            maxc = 0;
            foreach (vecs[i]) if (vecs[i].scn == s && vecs[i].cyc > maxc) maxc = vecs[i].cyc;
            do_reset();
            for (int c = 0; c <= maxc; c++) begin
                logic [3:0] e;
                logic [7:0] a, b, ar, rl;
                e = '0; a = '0; b = '0; ar = '0; rl = '0;
                foreach (vecs[i]) begin
                    if (vecs[i].scn == s && vecs[i].cyc == c) begin
                        if (vecs[i].chk) begin
                            check($sformatf("s%0d c%0d state", s, c), 32'(state), 32'(vecs[i].st));
                            check($sformatf("s%0d c%0d done", s, c), 32'(done), 32'(vecs[i].dn));
                            check($sformatf("s%0d c%0d timeout", s, c), 32'(timeout), 32'(vecs[i].to));
                            check($sformatf("s%0d c%0d error", s, c), 32'(error), 32'(vecs[i].er));
                            check($sformatf("s%0d c%0d cycle_cnt", s, c), cycle_cnt, 32'(c));
                        end else begin
                            e  = e | vecs[i].eos;
                            a  = a | vecs[i].aw;
                            b  = b | vecs[i].b;
                            ar = ar | vecs[i].ar;
                            rl = rl | vecs[i].rl;
                        end
                    end
                end
                cluster_eos = e;
                aw_fire     = a;
                b_fire      = b;
                ar_fire     = ar;
                r_last_fire = rl;
                tick();
            end
        end

        // Asynchronous reset mid-drain; EOS must be re-observed afterwards
        do_reset();
        cluster_eos = 4'hF;
        tick();
        cluster_eos = 4'h0;
        tick();
        check("rst_seq pre state", 32'(state), 32'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async state", 32'(state), 32'd0);
        check("rst_async cycle_cnt", cycle_cnt, 32'd0);
        check("rst_async flags", 32'({done, timeout, error}), 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("post_rst state", 32'(state), 32'd0);
        check("post_rst cycle_cnt", cycle_cnt, 32'd8);
        cluster_eos = 4'hF;
        tick();
        cluster_eos = 4'h0;
        repeat (5) tick();
        check("post_rst done", 32'(done), 32'd1);
        check("post_rst final state", 32'(state), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
